// File: rtl/onchip_ram_pkg.sv
// Shared types and elaboration helpers for the pipelined on-chip RAM.
// Used by onchip_ram_pipelined and onchip_ram_clear_seq.
package onchip_ram_pkg;

  typedef enum logic {CLEAR, READY} clr_state_t;

  function automatic int be_w(input int data_w);
    return data_w / 8;
  endfunction

  // True when the width/depth combination can be built.
  function automatic bit cfg_ok(input int data_w, input int addr_w, input int depth);
    return (data_w % 8 == 0) && (data_w >= 8) && (data_w <= 128) &&
           (addr_w >= 1) && (addr_w <= 31) && (depth >= 1) &&
           (longint'(depth) <= (longint'(1) << addr_w));
  endfunction

endpackage

// File: rtl/onchip_ram_clear_seq.sv
// Post-reset zero-clear sequencer: walks word addresses 0..DEPTH-1 writing zero,
// one word per unstalled cycle, then idles in READY until the next reset.
module onchip_ram_clear_seq
  import onchip_ram_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             stall,
  output logic             clearing,
  output logic [IDX_W-1:0] clr_addr,
  output logic             clr_we
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

  clr_state_t       state_reg, state_next;
  logic [IDX_W-1:0] count_reg, count_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= CLEAR;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    clearing   = 1'b0;
    clr_we     = 1'b0;
    case (state_reg)
      CLEAR: begin
        clearing = 1'b1;
        if (!stall) begin
          clr_we = 1'b1;
          if (count_reg == LAST) state_next = READY;
          else                   count_next = count_reg + 1'b1;
        end
      end
      default: state_next = READY;
    endcase
  end

  assign clr_addr = count_reg;

endmodule

// File: rtl/onchip_ram_pipelined.sv
// Single-port Avalon-MM pipelined RAM slave with byte lanes and read latency 1 or 2.
// Optional zero-clear after reset when ONCHIP_RAM_CLEAR_EN is defined.
module onchip_ram_pipelined
  import onchip_ram_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 14,
  parameter int DEPTH   = 10000,
  parameter int OUT_REG = 0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [ADDR_W-1:0]         address,
  input  logic [be_w(DATA_W)-1:0]   byteenable,
  input  logic                      chipselect,
  input  logic                      read,
  input  logic                      write,
  input  logic [DATA_W-1:0]         writedata,
  input  logic                      clken,
  input  logic                      reset_req,
  output logic [DATA_W-1:0]         readdata,
  output logic                      readdatavalid,
  output logic                      waitrequest
);

  localparam int BE_W  = be_w(DATA_W);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

  generate
    if (!cfg_ok(DATA_W, ADDR_W, DEPTH)) begin : g_cfg_err
      $error("onchip_ram_pipelined: illegal DATA_W/ADDR_W/DEPTH combination");
    end
  endgenerate

  logic             stall, clearing, accept, accept_read, accept_write, in_range;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] clr_addr;
  logic             clr_we;

  assign stall        = ~clken | reset_req;
  assign waitrequest  = stall | clearing | ~reset_n;
  assign accept       = chipselect & ~waitrequest;
  assign accept_write = accept & write;
  assign accept_read  = accept & read & ~write;
  assign in_range     = {1'b0, address} < DEPTH_X;
  assign idx          = address[IDX_W-1:0];

`ifdef ONCHIP_RAM_CLEAR_EN
  onchip_ram_clear_seq #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_clear_seq (
    .clk      (clk),
    .reset_n  (reset_n),
    .stall    (stall),
    .clearing (clearing),
    .clr_addr (clr_addr),
    .clr_we   (clr_we)
  );
`else
  assign clearing = 1'b0;
  assign clr_addr = '0;
  assign clr_we   = 1'b0;
`endif

  // The clear sequencer owns the single write port while it runs.
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [DATA_W-1:0] wr_data;
  logic [BE_W-1:0]  wr_be;

  always_comb begin
    wr_en   = accept_write & in_range;
    wr_idx  = idx;
    wr_data = writedata;
    wr_be   = byteenable;
    if (clearing) begin
      wr_en   = clr_we;
      wr_idx  = clr_addr;
      wr_data = '0;
      wr_be   = '1;
    end
  end

  logic [DATA_W-1:0] mem [0:DEPTH-1];
  logic [DATA_W-1:0] ram_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < BE_W; b++) begin
        if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // Read-after-write needs no bypass: the write lands on the edge before the read samples.
  always_ff @(posedge clk) begin
    if (accept_read) ram_q <= mem[idx];
  end

  logic              valid1_reg, in_range1_reg;
  logic [DATA_W-1:0] data1;
  logic              valid_last;
  logic [DATA_W-1:0] data_last;
  logic [DATA_W-1:0] held_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid1_reg    <= 1'b0;
      in_range1_reg <= 1'b0;
    end else if (!stall) begin
      valid1_reg <= accept_read;
      if (accept_read) in_range1_reg <= in_range;
    end
  end

  assign data1 = in_range1_reg ? ram_q : '0;

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic              valid2_reg;
      logic [DATA_W-1:0] data2_reg;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    valid2_reg <= 1'b0;
        else if (!stall) valid2_reg <= valid1_reg;
      end

      always_ff @(posedge clk) begin
        if (!stall && valid1_reg) data2_reg <= data1;
      end

      assign valid_last = valid2_reg;
      assign data_last  = data2_reg;
    end else begin : g_no_out_reg
      assign valid_last = valid1_reg;
      assign data_last  = data1;
    end
  endgenerate

  assign readdatavalid = valid_last & ~stall;

  // readdata shows the last delivered word whenever nothing is being delivered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)           held_reg <= '0;
    else if (readdatavalid) held_reg <= data_last;
  end

  assign readdata = readdatavalid ? data_last : held_reg;

endmodule
